// File: rtl/obc_accumulator.sv
// Offset-binary-coded DA accumulator: sums eight signed ROM partials per bit-serial
// beat and accumulates them with binary weights. Optional saturation: OBC_SAT_EN.
module obc_accumulator #(
    parameter int DATA_W    = 16,
    parameter int ROM_W     = 32,
    parameter int ACC_W     = 52,
    parameter int OUT_W     = 32,
    parameter int OUT_SHIFT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ROM_W-1:0] rom0,
    input  logic [ROM_W-1:0] rom1,
    input  logic [ROM_W-1:0] rom2,
    input  logic [ROM_W-1:0] rom3,
    input  logic [ROM_W-1:0] rom4,
    input  logic [ROM_W-1:0] rom5,
    input  logic [ROM_W-1:0] rom6,
    input  logic [ROM_W-1:0] rom7,
    input  logic [ROM_W-1:0] offset_in,
    input  logic             in_valid,
    input  logic             frame_start,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] result
);

    localparam int P_W   = ROM_W + 3;
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                   state_r;
    logic [CNT_W-1:0]         cnt_r;
    logic signed [ACC_W-1:0]  acc_r;
    logic                     out_valid_r;
    logic [OUT_W-1:0]         result_r;

    logic [ROM_W-1:0]         rom_arr_s [8];
    logic signed [P_W-1:0]    psum_s;
    logic signed [ACC_W-1:0]  p_ext_s;
    logic signed [ACC_W-1:0]  p_sh_s;
    logic signed [ACC_W-1:0]  off_ext_s;
    logic signed [ACC_W-1:0]  load_s;
    logic signed [ACC_W-1:0]  next_acc_s;
    logic signed [ACC_W-1:0]  final_s;
    logic signed [ACC_W-1:0]  msb_only_s;
    logic                     accept_s;

    // Shift the exact sum down, then wrap or clamp it into the result width.
    function automatic logic [OUT_W-1:0] reduce_out(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] sh;
        sh = s >>> OUT_SHIFT;
`ifdef OBC_SAT_EN
        if ((&sh[ACC_W-1:OUT_W-1]) || (~|sh[ACC_W-1:OUT_W-1])) begin
            return sh[OUT_W-1:0];
        end else if (sh[ACC_W-1]) begin
            return {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            return {1'b0, {(OUT_W-1){1'b1}}};
        end
`else
        return sh[OUT_W-1:0];
`endif
    endfunction

    assign rom_arr_s[0] = rom0;
    assign rom_arr_s[1] = rom1;
    assign rom_arr_s[2] = rom2;
    assign rom_arr_s[3] = rom3;
    assign rom_arr_s[4] = rom4;
    assign rom_arr_s[5] = rom5;
    assign rom_arr_s[6] = rom6;
    assign rom_arr_s[7] = rom7;

    // Beat sum with three guard bits so eight full-range partials cannot overflow.
    always_comb begin
        psum_s = '0;
        for (int i = 0; i < 8; i++) begin
            psum_s = psum_s + {{3{rom_arr_s[i][ROM_W-1]}}, rom_arr_s[i]};
        end
    end

    assign p_ext_s    = {{(ACC_W-P_W){psum_s[P_W-1]}}, psum_s};
    assign off_ext_s  = {{(ACC_W-ROM_W){offset_in[ROM_W-1]}}, offset_in};
    assign p_sh_s     = p_ext_s <<< cnt_r;
    assign load_s     = off_ext_s + p_ext_s;
    assign msb_only_s = off_ext_s - p_ext_s;
    assign next_acc_s = acc_r + p_sh_s;
    assign final_s    = acc_r - p_sh_s;

    assign in_ready  = (state_r != HOLD);
    assign accept_s  = in_valid & in_ready;
    assign out_valid = out_valid_r;
    assign result    = result_r;

    // Frame sequencer; the MSB beat carries negative weight (two's-complement input).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            acc_r       <= '0;
            out_valid_r <= 1'b0;
            result_r    <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s && frame_start) begin
                        if (DATA_W == 1) begin
                            acc_r       <= msb_only_s;
                            result_r    <= reduce_out(msb_only_s);
                            out_valid_r <= 1'b1;
                            cnt_r       <= '0;
                            state_r     <= HOLD;
                        end else begin
                            acc_r   <= load_s;
                            cnt_r   <= CNT_W'(1);
                            state_r <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept_s) begin
                        if (frame_start) begin
                            acc_r <= load_s;
                            cnt_r <= CNT_W'(1);
                        end else if (cnt_r == LAST_CNT) begin
                            acc_r       <= final_s;
                            result_r    <= reduce_out(final_s);
                            out_valid_r <= 1'b1;
                            cnt_r       <= '0;
                            state_r     <= HOLD;
                        end else begin
                            acc_r <= next_acc_s;
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    cnt_r       <= '0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obc_accumulator.sv
// Scoreboard bench for obc_accumulator: DATA_W=16, OUT_SHIFT=0, OUT_W=32 main DUT,
// plus an OUT_W=16 copy for the result-width overflow case (OBC_SAT_EN aware).
module tb_obc_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] rom0, rom1, rom2, rom3, rom4, rom5, rom6, rom7;
    logic [31:0] offset_in;
    logic        in_valid, frame_start, out_ready;
    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [31:0] result;
    logic [15:0] result2;

    int checks = 0;
    int failures = 0;

    logic signed [31:0] br [16][8];
    logic signed [31:0] boff;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    obc_accumulator #(.DATA_W(16), .ROM_W(32), .ACC_W(52), .OUT_W(32), .OUT_SHIFT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .rom0(rom0), .rom1(rom1), .rom2(rom2), .rom3(rom3),
        .rom4(rom4), .rom5(rom5), .rom6(rom6), .rom7(rom7),
        .offset_in(offset_in), .in_valid(in_valid), .frame_start(frame_start),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .result(result)
    );

    obc_accumulator #(.DATA_W(16), .ROM_W(32), .ACC_W(52), .OUT_W(16), .OUT_SHIFT(0)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .rom0(rom0), .rom1(rom1), .rom2(rom2), .rom3(rom3),
        .rom4(rom4), .rom5(rom5), .rom6(rom6), .rom7(rom7),
        .offset_in(offset_in), .in_valid(in_valid), .frame_start(frame_start),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_ready(out_ready),
        .result(result2)
    );

    // Reference sum: offset + weighted beat sums, MSB beat negative.
    function automatic longint model_s();
        longint s;
        longint p;
        s = longint'(boff);
        for (int j = 0; j < 16; j++) begin
            p = 0;
            for (int k = 0; k < 8; k++) p = p + longint'(br[j][k]);
            if (j == 15) s = s - p * (longint'(1) << j);
            else         s = s + p * (longint'(1) << j);
        end
        return s;
    endfunction

    function automatic logic [31:0] model32();
        longint s;
        s = model_s();
        return s[31:0];
    endfunction

    task automatic clear_frame();
        for (int j = 0; j < 16; j++)
            for (int k = 0; k < 8; k++) br[j][k] = 32'sd0;
        boff = 32'sd0;
    endtask

    task automatic rand_frame();
        for (int j = 0; j < 16; j++)
            for (int k = 0; k < 8; k++) br[j][k] = $urandom;
        boff = $urandom;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int j, input logic fs);
        rom0 = br[j][0]; rom1 = br[j][1]; rom2 = br[j][2]; rom3 = br[j][3];
        rom4 = br[j][4]; rom5 = br[j][5]; rom6 = br[j][6]; rom7 = br[j][7];
        offset_in   = boff;
        frame_start = fs;
        in_valid    = 1'b1;
    endtask

    task automatic send_beat(input int j, input logic fs, input int gap);
        int waitc;
        in_valid = 1'b0;
        repeat (gap) tick();
        drive_beat(j, fs);
        waitc = 0;
        while (in_ready !== 1'b1 && waitc < 50) begin
            tick();
            waitc++;
        end
        if (waitc >= 50) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout beat=%0d in_ready=%b required=1", j, in_ready);
        end
        tick();
        in_valid    = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic send_frame(input int maxgap);
        for (int j = 0; j < 16; j++)
            send_beat(j, (j == 0), (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    endtask

    task automatic collect(input string name);
        int waitc;
        logic [31:0] e;
        waitc = 0;
        while (out_valid !== 1'b1 && waitc < 50) begin
            tick();
            waitc++;
        end
        checks++;
        if (waitc >= 50) begin
            failures++;
            $display("FAIL %s_timeout out_valid=%b required=1", name, out_valid);
        end
        if (exp_q.size() == 0) begin
            e = 32'hDEAD_BEEF;
            failures++;
            $display("FAIL %s_queue_empty got=%h required=<expected entry>", name, result);
        end else begin
            e = exp_q.pop_front();
        end
        checks++;
        if (result !== e) begin
            failures++;
            $display("FAIL %s_result got=%h required=%h", name, result, e);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_release out_valid=%b required=0", name, out_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
        rom0 = 32'd0; rom1 = 32'd0; rom2 = 32'd0; rom3 = 32'd0;
        rom4 = 32'd0; rom5 = 32'd0; rom6 = 32'd0; rom7 = 32'd0; offset_in = 32'd0;
        #23;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
        checks++;
        if (result !== 32'd0) begin failures++; $display("FAIL reset_result got=%h required=0", result); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_all_ones();
        clear_frame();
        for (int j = 0; j < 16; j++)
            for (int k = 0; k < 8; k++) br[j][k] = 32'sd1;
        exp_q.push_back(model32());
        for (int j = 0; j < 15; j++) send_beat(j, (j == 0), 0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL ones_early_valid got=%b required=0", out_valid); end
        send_beat(15, 1'b0, 0);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL ones_latency got=%b required=1", out_valid); end
        collect("all_ones");
    endtask

    task automatic test_stall();
        clear_frame();
        br[0][0] = 32'sd5;
        boff = 32'sd3;
        exp_q.push_back(model32());
        send_frame(4);
        collect("stall");
    endtask

    task automatic test_msb_and_abort();
        clear_frame();
        br[15][0] = 32'sd1;
        exp_q.push_back(model32());
        send_frame(0);
        collect("msb_only");
        // Junk frame aborted at beat 7 by a fresh frame_start.
        for (int j = 0; j < 16; j++) br[j][0] = 32'sd3;
        boff = 32'sd11;
        for (int j = 0; j < 7; j++) send_beat(j, (j == 0), 0);
        clear_frame();
        br[15][0] = 32'sd1;
        exp_q.push_back(model32());
        for (int j = 0; j < 15; j++) send_beat(j, (j == 0), 0);
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL abort_early_valid got=%b required=0", out_valid); end
        send_beat(15, 1'b0, 0);
        collect("abort_restart");
    endtask

    task automatic test_saturation();
        logic [15:0] e16;
        clear_frame();
        br[15][0] = -32'sd1048576;
`ifdef OBC_SAT_EN
        e16 = 16'h7FFF;
`else
        e16 = 16'h0000;
`endif
        exp_q.push_back(model32());
        send_frame(0);
        checks++;
        if (out_valid2 !== 1'b1 || result2 !== e16) begin
            failures++;
            $display("FAIL sat16 valid=%b got=%h required=%h", out_valid2, result2, e16);
        end
        collect("sat_wide");
    endtask

    task automatic test_hold_backpressure();
        logic [31:0] ea, eb;
        rand_frame();
        ea = model32();
        send_frame(1);
        rand_frame();
        eb = model32();
        drive_beat(0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (in_ready !== 1'b0 || in_ready2 !== 1'b0 || out_valid !== 1'b1 || result !== ea) begin
                failures++;
                $display("FAIL hold_cycle%0d in_ready=%b valid=%b got=%h required=%h", c, in_ready, out_valid, result, ea);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_handshake valid=%b in_ready=%b required valid=0 in_ready=1", out_valid, in_ready);
        end
        exp_q.push_back(eb);
        send_beat(0, 1'b1, 0);
        for (int j = 1; j < 16; j++) send_beat(j, 1'b0, 0);
        collect("after_hold");
    endtask

    task automatic test_reset_mid_frame();
        int seen;
        rand_frame();
        for (int j = 0; j < 9; j++) send_beat(j, (j == 0), 0);
        drive_beat(9, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== 32'd0) begin
            failures++;
            $display("FAIL midreset valid=%b in_ready=%b got=%h required valid=0 in_ready=1 result=0", out_valid, in_ready, result);
        end
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL midreset_spurious valid_cycles=%0d required=0", seen); end
        rand_frame();
        exp_q.push_back(model32());
        send_frame(2);
        collect("post_reset");
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 4; f++) begin
            rand_frame();
            exp_q.push_back(model32());
            send_frame(f);
            collect("random");
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_stall();
        test_msb_and_abort();
        test_saturation();
        test_hold_backpressure();
        test_random_frames();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obc_accumulator.md
OBC_ACCUMULATOR -- requirements
Module: obc_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bit-serial beats per frame (input sample width).
REQ-002 SHALL have parameter ROM_W, default 32, meaning width of each signed ROM partial input.
REQ-003 SHALL have parameter ACC_W, default 52, meaning signed accumulator width.
REQ-004 SHALL have parameter OUT_W, default 32, meaning result width.
REQ-005 SHALL have parameter OUT_SHIFT, default 16, meaning arithmetic right shift applied to the final sum before output.
REQ-006 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-007 SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-008 SHALL have ports rom0..rom7, input, ROM_W each, meaning signed two's-complement partials from the OBC ROM for the current bit slice.
REQ-009 SHALL have port offset_in, input, ROM_W, meaning signed OBC offset term, sampled on the first beat.
REQ-010 SHALL have port in_valid, input, 1, meaning a rom0..rom7 beat is present.
REQ-011 SHALL have port frame_start, input, 1, meaning qualifies the beat as bit 0 (LSB) of a frame.
REQ-012 SHALL have port in_ready, output, 1, meaning a beat is accepted when in_valid and in_ready are both high.
REQ-013 SHALL have port out_valid, output, 1, meaning result holds a completed frame.
REQ-014 SHALL have port out_ready, input, 1, meaning the consumer takes result when out_valid and out_ready are both high.
REQ-015 SHALL have port result, output, OUT_W, meaning the signed DFT bin value.

Function
REQ-016 SHALL form beat sum P = sign-extended sum of rom0..rom7, with at least ROM_W+3 bits and no overflow.
REQ-017 SHALL compute, over beats j=0..DATA_W-1, S = offset_in + sum(j<DATA_W-1) P_j*2^j - P_(DATA_W-1)*2^(DATA_W-1), held exactly in ACC_W bits.
REQ-018 SHALL output result = S arithmetically shifted right by OUT_SHIFT, then reduced to OUT_W bits per REQ-031/REQ-032.
REQ-019 SHALL implement the FSM states IDLE, ACC and HOLD.
REQ-020 SHALL, in IDLE, ignore accepted beats without frame_start.
REQ-021 SHALL, in IDLE, on an accepted beat with frame_start, load acc = offset_in + P_0 and bit count 1, then enter ACC.
REQ-022 SHALL, in ACC, advance the bit count by one on each accepted beat.
REQ-023 SHALL, in ACC, on the accepted beat with bit count DATA_W-1, subtract the shifted P and enter HOLD.
REQ-024 SHALL, in ACC with in_valid low, hold acc and the bit count (stall, any length).
REQ-025 SHALL, in ACC, treat a beat with frame_start as an abort: reload per REQ-021 and remain in ACC.
REQ-026 SHALL, in HOLD, keep out_valid high and result stable until out_ready is high, then enter IDLE.
REQ-027 SHALL drive in_ready high in IDLE and ACC and low in HOLD, decoded from the registered state only.
REQ-028 SHALL assert out_valid on the cycle after the final beat is accepted (1-cycle latency).
REQ-029 SHALL NOT accept a beat in the same cycle as a HOLD handshake, because in_ready stays low; the next frame may start the following cycle.
REQ-030 SHALL, when DATA_W is 1, treat the single beat as MSB: S = offset_in - P_0, entering HOLD directly from IDLE.

Configuration
REQ-031 SHALL, with macro OBC_SAT_EN defined, saturate the shifted S to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-032 SHALL, without OBC_SAT_EN, truncate the shifted S to its low OUT_W bits (wrap).

Reset
REQ-033 SHALL, on rst_n low, asynchronously force state IDLE, bit count 0, acc 0, result 0, out_valid 0 and in_ready 1.
REQ-034 SHALL, on reset mid-frame or mid-HOLD, discard the pending frame with no out_valid pulse after release.

Verification (DATA_W=16, OUT_SHIFT=0, OUT_W=32 unless stated)
REQ-035 SHALL cover: all rom=1 on 16 consecutive beats, offset_in=0 -> result=-8 (0xFFFFFFF8), out_valid one cycle after beat 15.
REQ-036 SHALL cover: beat 0 rom0=5 with others 0, offset_in=3, random in_valid gaps -> result=8, with stalls not altering the value.
REQ-037 SHALL cover: only beat 15 rom0=1 -> result=-32768; repeat with frame_start reasserted at beat 7 -> frame restarts and result comes 16 accepted beats later.
REQ-038 SHALL cover: OUT_W=16, beat 15 rom0=-2^20 -> with OBC_SAT_EN result=0x7FFF, without result=0x0000.
REQ-039 SHALL cover: out_ready low for 5 cycles in HOLD with in_valid high -> in_ready=0, result stable, no beat consumed; the next frame starts the cycle after the handshake.
REQ-040 SHALL cover: rst_n pulsed low at beat 9 -> outputs reset immediately, no out_valid; a subsequent full frame yields the correct result.
